// File: rtl/eae_seq_if.sv
// eae_seq_if: handshake and data bundle between the CPU controller and the
// sequential EAE.
//   master (controller): drives start, abort, op, ac_in, mq_in, operand;
//                        observes busy, done, ac_out, mq_out, link_out, sc_out
//   slave  (eae_seq)   : the reverse
interface eae_seq_if #(
    parameter int WIDTH = 12,
    parameter int SCW   = $clog2(2*WIDTH)
);
    logic             start;
    logic             abort;
    logic [1:0]       op;
    logic [WIDTH-1:0] ac_in;
    logic [WIDTH-1:0] mq_in;
    logic [WIDTH-1:0] operand;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] ac_out;
    logic [WIDTH-1:0] mq_out;
    logic             link_out;
    logic [SCW-1:0]   sc_out;

    modport master (
        output start, abort, op, ac_in, mq_in, operand,
        input  busy, done, ac_out, mq_out, link_out, sc_out
    );

    modport slave (
        input  start, abort, op, ac_in, mq_in, operand,
        output busy, done, ac_out, mq_out, link_out, sc_out
    );
endinterface

// File: rtl/eae_seq.sv
// eae_seq: iterative PDP-8 Extended Arithmetic Element (MUL, DVI, NMI) on an
// AC:MQ pair of WIDTH bits, one bit of work per clock.
// Ports:
//   clock   - rising-edge clock
//   resetN  - asynchronous active-low reset
//   bus     - eae_seq_if.slave: start/abort/op and operands in,
//             busy/done handshake and AC/MQ/link/SC results out
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; DVI overflow resolved here directly
// MUL_RUN | shift-add multiply, WIDTH iterations
// DVI_RUN | restoring divide, WIDTH iterations
// NMI_RUN | normalise: test termination, else shift left and count
// DONE    | one-cycle done pulse, results already loaded
module eae_seq #(
    parameter int WIDTH = 12,
    parameter int SCW   = $clog2(2*WIDTH)
) (
    input  logic      clock,
    input  logic      resetN,
    eae_seq_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, MUL_RUN, DVI_RUN, NMI_RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] ac, mq, opnd;
    logic [SCW-1:0]   cnt, sc;

    logic             busy_q, done_q, link_q;
    logic [WIDTH-1:0] ac_q, mq_q;
    logic [SCW-1:0]   sc_q;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_ac, mul_mq;
    logic [WIDTH:0]   dvi_rem;
    logic [WIDTH-1:0] dvi_ac, dvi_mq;
    logic             nmi_term, dvi_ovf, last_iter;

    always_comb begin
        // Multiply step: conditional add with carry, then {carry,ac,mq} >> 1.
        mul_sum = {1'b0, ac} + (mq[0] ? {1'b0, opnd} : '0);
        mul_ac  = mul_sum[WIDTH:1];
        mul_mq  = {mul_sum[0], mq[WIDTH-1:1]};

        // Divide step: the partial remainder needs WIDTH+1 bits because the
        // bit shifted out of AC still counts in the compare. The difference
        // always fits in WIDTH bits since the remainder stays below opnd.
        dvi_rem = {ac, mq[WIDTH-1]};
        if (dvi_rem >= {1'b0, opnd}) begin
            dvi_ac = dvi_rem[WIDTH-1:0] - opnd;
            dvi_mq = {mq[WIDTH-2:0], 1'b1};
        end else begin
            dvi_ac = dvi_rem[WIDTH-1:0];
            dvi_mq = {mq[WIDTH-2:0], 1'b0};
        end

        nmi_term  = (ac[WIDTH-1] != ac[WIDTH-2])
                 || ({ac, mq} == {2'b11, {(2*WIDTH-2){1'b0}}})
                 || ({ac, mq} == '0);
        // Covers divide by zero too: any ac_in >= 0.
        dvi_ovf   = bus.ac_in >= bus.operand;
        last_iter = (cnt == SCW'(WIDTH-1));
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state  <= IDLE;
            ac     <= '0;
            mq     <= '0;
            opnd   <= '0;
            cnt    <= '0;
            sc     <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            link_q <= 1'b0;
            ac_q   <= '0;
            mq_q   <= '0;
            sc_q   <= '0;
        end else if (bus.abort) begin
            // Result registers are deliberately left at the last completed op.
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        ac   <= bus.ac_in;
                        mq   <= bus.mq_in;
                        opnd <= bus.operand;
                        cnt  <= '0;
                        sc   <= '0;
                        case (bus.op)
                            2'b00: begin
                                state  <= MUL_RUN;
                                busy_q <= 1'b1;
                            end
                            2'b01: begin
                                if (dvi_ovf) begin
                                    state  <= DONE;
                                    done_q <= 1'b1;
                                    ac_q   <= bus.ac_in;
                                    mq_q   <= bus.mq_in;
                                    link_q <= 1'b1;
                                    sc_q   <= '0;
                                end else begin
                                    state  <= DVI_RUN;
                                    busy_q <= 1'b1;
                                end
                            end
                            default: begin
                                // 11 is reserved and runs as NMI.
                                state  <= NMI_RUN;
                                busy_q <= 1'b1;
                            end
                        endcase
                    end
                end
                MUL_RUN: begin
                    ac  <= mul_ac;
                    mq  <= mul_mq;
                    cnt <= cnt + SCW'(1);
                    if (last_iter) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        ac_q   <= mul_ac;
                        mq_q   <= mul_mq;
                        link_q <= 1'b0;
                        sc_q   <= '0;
                    end
                end
                DVI_RUN: begin
                    ac  <= dvi_ac;
                    mq  <= dvi_mq;
                    cnt <= cnt + SCW'(1);
                    if (last_iter) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        ac_q   <= dvi_ac;
                        mq_q   <= dvi_mq;
                        link_q <= 1'b0;
                        sc_q   <= '0;
                    end
                end
                NMI_RUN: begin
                    if (nmi_term) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        ac_q   <= ac;
                        mq_q   <= mq;
                        link_q <= 1'b0;
                        sc_q   <= sc;
                    end else begin
                        ac <= {ac[WIDTH-2:0], mq[WIDTH-1]};
                        mq <= {mq[WIDTH-2:0], 1'b0};
                        sc <= sc + SCW'(1);
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.ac_out   = ac_q;
    assign bus.mq_out   = mq_q;
    assign bus.link_out = link_q;
    assign bus.sc_out   = sc_q;
endmodule

// File: tb/tb_eae_seq.sv
// tb_eae_seq: randomized and directed checks of eae_seq at WIDTH=12 and
// WIDTH=16 against an arithmetic reference model.
module tb_eae_seq;
    logic clock = 1'b0;
    logic resetN = 1'b0;
    always #5 clock = ~clock;

    eae_seq_if #(.WIDTH(12)) b12 ();
    eae_seq_if #(.WIDTH(16)) b16 ();

    eae_seq #(.WIDTH(12)) dut12 (.clock(clock), .resetN(resetN), .bus(b12));
    eae_seq #(.WIDTH(16)) dut16 (.clock(clock), .resetN(resetN), .bus(b16));

    // Common stimulus; sel routes start/abort to one instance.
    logic        sel = 1'b0, start = 1'b0, abort = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [15:0] ac_in = '0, mq_in = '0, operand = '0;

    assign b12.start   = start & ~sel;
    assign b12.abort   = abort & ~sel;
    assign b12.op      = op;
    assign b12.ac_in   = ac_in[11:0];
    assign b12.mq_in   = mq_in[11:0];
    assign b12.operand = operand[11:0];
    assign b16.start   = start & sel;
    assign b16.abort   = abort & sel;
    assign b16.op      = op;
    assign b16.ac_in   = ac_in;
    assign b16.mq_in   = mq_in;
    assign b16.operand = operand;

    logic        done_s, busy_s, link_o;
    logic [15:0] ac_o, mq_o;
    logic [4:0]  sc_o;
    assign done_s = sel ? b16.done     : b12.done;
    assign busy_s = sel ? b16.busy     : b12.busy;
    assign link_o = sel ? b16.link_out : b12.link_out;
    assign ac_o   = sel ? b16.ac_out   : {4'b0, b12.ac_out};
    assign mq_o   = sel ? b16.mq_out   : {4'b0, b12.mq_out};
    assign sc_o   = sel ? b16.sc_out   : b12.sc_out;

    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] e_ac, e_mq, e_link, e_sc, e_lat;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain arithmetic on the 2W-bit value.
    function automatic void model(input int w, input logic [1:0] o,
                                  input logic [63:0] a, input logic [63:0] m, input logic [63:0] d,
                                  output logic [63:0] ea, output logic [63:0] em, output logic [63:0] el,
                                  output logic [63:0] es, output logic [63:0] elat);
        logic [63:0] mask, mask2, p, v;
        int n, lead, sh;
        logic msb;
        mask  = (64'd1 << w) - 1;
        mask2 = (64'd1 << (2*w)) - 1;
        ea = 0; em = 0; el = 0; es = 0; elat = w + 1;
        if (o == 2'b00) begin
            p  = m * d + a;
            ea = (p >> w) & mask;
            em = p & mask;
        end else if (o == 2'b01) begin
            if (a >= d) begin
                ea = a; em = m; el = 1; elat = 1;
            end else begin
                p  = (a << w) | m;
                em = p / d;
                ea = p % d;
            end
        end else begin
            n = 2*w;
            v = (a << w) | m;
            sh = 0;
            if (v != 0) begin
                msb = v[n-1];
                lead = 0;
                for (int i = n-1; i >= 0; i--) begin
                    if (v[i] != msb) break;
                    lead++;
                end
                // Leading ones followed only by zeros stops at 110...0.
                if (msb && lead >= 2 && ((v & ((64'd1 << (n-lead)) - 1)) == 0))
                    sh = lead - 2;
                else
                    sh = lead - 1;
            end
            v    = (v << sh) & mask2;
            ea   = v >> w;
            em   = v & mask;
            es   = sh;
            elat = sh + 2;
        end
    endfunction

    task automatic run_op(input logic s, input logic [1:0] o, input logic [15:0] a,
                          input logic [15:0] m, input logic [15:0] d, input string tag);
        int cyc;
        logic got, busy_ok;
        model(s ? 16 : 12, o, a, m, d, e_ac, e_mq, e_link, e_sc, e_lat);
        @(negedge clock);
        sel = s; op = o; ac_in = a; mq_in = m; operand = d; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        cyc = 0; got = 1'b0; busy_ok = 1'b1;
        while (!got && cyc < 80) begin
            @(negedge clock);
            cyc++;
            if (done_s) got = 1'b1;
            else if (!busy_s) busy_ok = 1'b0;
        end
        check_val({tag, ".latency"}, cyc, e_lat);
        check_val({tag, ".busy_run"}, busy_ok, 1);
        check_val({tag, ".busy_at_done"}, busy_s, 0);
        check_val({tag, ".ac"}, ac_o, e_ac);
        check_val({tag, ".mq"}, mq_o, e_mq);
        check_val({tag, ".link"}, link_o, e_link);
        check_val({tag, ".sc"}, sc_o, e_sc);
        @(negedge clock);
        check_val({tag, ".done_pulse"}, done_s, 0);
    endtask

    initial begin
        logic [63:0] p_ac, p_mq, p_link, p_sc, x_lat;
        logic [15:0] mask, a, m, d;
        logic [1:0]  o;
        logic        s, seen;
        int          cyc;

        repeat (3) @(negedge clock);
        resetN = 1'b1;
        @(negedge clock);
        for (int k = 0; k < 2; k++) begin
            sel = k[0];
            #1;
            check_val("reset.busy", busy_s, 0);
            check_val("reset.done", done_s, 0);
            check_val("reset.ac", ac_o, 0);
            check_val("reset.mq", mq_o, 0);
            check_val("reset.link", link_o, 0);
            check_val("reset.sc", sc_o, 0);
        end

        // Directed cases, with hard constants alongside the model.
        run_op(0, 2'b00, 16'o0002, 16'o0005, 16'o0003, "mul_small");
        check_val("mul_small.const_mq", mq_o, 16'o0021);
        run_op(0, 2'b00, 16'o7777, 16'o7777, 16'o7777, "mul_max");
        check_val("mul_max.const_ac", ac_o, 16'o7777);
        check_val("mul_max.const_mq", mq_o, 16'o0000);
        run_op(0, 2'b01, 16'o0000, 16'o0144, 16'o0007, "dvi_small");
        check_val("dvi_small.const_mq", mq_o, 16'o0016);
        check_val("dvi_small.const_ac", ac_o, 16'o0002);
        run_op(0, 2'b01, 16'o0010, 16'o1234, 16'o0007, "dvi_ovf");
        check_val("dvi_ovf.const_link", link_o, 1);
        run_op(0, 2'b01, 16'o0010, 16'o4321, 16'o0000, "dvi_zero");
        check_val("dvi_zero.const_mq", mq_o, 16'o4321);
        run_op(0, 2'b10, 16'o0000, 16'o0001, 16'o0000, "nmi_one");
        check_val("nmi_one.const_ac", ac_o, 16'o2000);
        check_val("nmi_one.const_sc", sc_o, 22);
        run_op(0, 2'b10, 16'o0000, 16'o0000, 16'o0000, "nmi_zero");
        run_op(0, 2'b11, 16'o7777, 16'o7777, 16'o0000, "nmi_res_ones");
        check_val("nmi_res_ones.const_ac", ac_o, 16'o6000);
        run_op(0, 2'b10, 16'o0377, 16'o0000, 16'o0000, "nmi_pos");
        run_op(1, 2'b00, 16'o0002, 16'o0005, 16'o0003, "w16_mul");
        check_val("w16_mul.const_lat", e_lat, 17);
        run_op(1, 2'b01, 16'o0000, 16'o0144, 16'o0007, "w16_dvi");
        check_val("w16_dvi.const_mq", mq_o, 16'o0016);

        // Randomized operations on both widths.
        for (int i = 0; i < 60; i++) begin
            s    = 1'($urandom_range(0, 1));
            mask = s ? 16'hFFFF : 16'h0FFF;
            o    = 2'($urandom_range(0, 3));
            a    = 16'($urandom) & mask;
            m    = 16'($urandom) & mask;
            d    = 16'($urandom) & mask;
            if (o == 2'b01 && $urandom_range(0, 3) != 0)
                a = (d == 0) ? 16'd0 : a % d;
            if (o[1] && $urandom_range(0, 1) == 1) begin
                a = 16'($urandom_range(0, 3));
                m = m >> $urandom_range(0, s ? 15 : 11);
            end
            run_op(s, o, a, m, d, "rnd");
        end

        // Abort mid-MUL: no done, previous results held.
        run_op(0, 2'b00, 16'o0123, 16'o0456, 16'o0077, "pre_abort");
        p_ac = e_ac; p_mq = e_mq; p_link = e_link; p_sc = e_sc;
        @(negedge clock);
        sel = 0; op = 2'b00; ac_in = 16'o7777; mq_in = 16'o1111; operand = 16'o2222; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (4) @(negedge clock);
        abort = 1'b1;
        @(posedge clock);
        #1 abort = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clock);
            if (done_s) seen = 1'b1;
        end
        check_val("abort.no_done", seen, 0);
        check_val("abort.busy", busy_s, 0);
        check_val("abort.ac_held", ac_o, p_ac);
        check_val("abort.mq_held", mq_o, p_mq);
        check_val("abort.link_held", link_o, p_link);
        check_val("abort.sc_held", sc_o, p_sc);

        // Abort and start together: start dropped.
        @(negedge clock);
        op = 2'b10; ac_in = 0; mq_in = 1; start = 1'b1; abort = 1'b1;
        @(posedge clock);
        #1 begin start = 1'b0; abort = 1'b0; end
        seen = 1'b0;
        repeat (30) begin
            @(negedge clock);
            if (done_s || busy_s) seen = 1'b1;
        end
        check_val("abort_start.dropped", seen, 0);

        // Start while busy is ignored.
        model(12, 2'b00, 16'o0012, 16'o0345, 16'o0067, p_ac, p_mq, p_link, p_sc, x_lat);
        @(negedge clock);
        op = 2'b00; ac_in = 16'o0012; mq_in = 16'o0345; operand = 16'o0067; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        cyc = 0;
        repeat (3) begin @(negedge clock); cyc++; end
        op = 2'b01; ac_in = 16'o0001; mq_in = 16'o7070; operand = 16'o0003; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        seen = 1'b0;
        while (!seen && cyc < 80) begin
            @(negedge clock);
            cyc++;
            if (done_s) seen = 1'b1;
        end
        check_val("busy_start.latency", cyc, x_lat);
        check_val("busy_start.ac", ac_o, p_ac);
        check_val("busy_start.mq", mq_o, p_mq);
        @(negedge clock);
        check_val("busy_start.no_second", busy_s, 0);

        // Asynchronous reset mid-DVI.
        @(negedge clock);
        op = 2'b01; ac_in = 16'o0000; mq_in = 16'o0144; operand = 16'o0007; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (5) @(negedge clock);
        #2 resetN = 1'b0;
        #1;
        check_val("rst_mid.busy", busy_s, 0);
        check_val("rst_mid.ac", ac_o, 0);
        check_val("rst_mid.mq", mq_o, 0);
        check_val("rst_mid.link", link_o, 0);
        check_val("rst_mid.sc", sc_o, 0);
        @(negedge clock);
        resetN = 1'b1;
        repeat (3) @(negedge clock);
        check_val("rst_mid.idle_done", done_s, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/eae_seq.md
# eae_seq

Parametrised sequential Extended Arithmetic Element (EAE) for the PDP-8 datapath. It replaces the single-cycle `ac_mul`/`mq_mul`/`ac_dvi`/`mq_dvi`/`link_dvi` sources with one iterative unit that performs MUL, DVI and NMI on an AC:MQ pair of configurable word width. It sits beside the CPU register block. The controller starts an operation with a start/busy/done handshake and loads the results into AC, MQ, link and SC when `done` pulses.

## Interface
- `WIDTH`, 12: word width of AC, MQ and the operand; must be ≥ 4.
- `SCW`, `$clog2(2*WIDTH)`: width of the shift-count output.

- `clock`  in  1  rising-edge clock.
- `resetN`  in  1  reset, asynchronous and active-low.
- `start`  in  1  one-cycle request; accepted only while `busy`=0.
- `abort`  in  1  cancels any operation in progress; returns to IDLE with no `done`.
- `op`  in  2  operation select: 00 MUL, 01 DVI, 10 NMI, 11 reserved (treated as NMI).
- `ac_in`  in  WIDTH  AC operand, sampled on the start cycle.
- `mq_in`  in  WIDTH  MQ operand, sampled on the start cycle.
- `operand`  in  WIDTH  memory operand (multiplier or divisor), sampled on the start cycle; ignored for NMI.
- `busy`  out  1  high from the cycle after an accepted start until `done`.
- `done`  out  1  one-cycle pulse when results are valid.
- `ac_out`  out  WIDTH  result AC; holds until the next accepted start.
- `mq_out`  out  WIDTH  result MQ; same hold rule as `ac_out`.
- `link_out`  out  1  result link; same hold rule as `ac_out`.
- `sc_out`  out  SCW  shift count (NMI only; 0 for MUL and DVI).

## Operation
- FSM states: IDLE, MUL_RUN, DVI_RUN, NMI_RUN, DONE.
- IDLE behaviour:
  - `start`=1 latches the operands, clears the iteration counter, and moves to the state selected by `op`.
  - DVI overflow check happens on the start cycle. Overflow is `ac_in` ≥ `operand`, which includes divide by zero. On overflow, go directly to DONE with `ac_out`=`ac_in`, `mq_out`=`mq_in`, `link_out`=1.
- MUL: computes `{ac_out,mq_out}` = `mq_in`×`operand` + `ac_in`, with `link_out`=0.
  - Shift-add method, one multiplier bit per cycle, WIDTH cycles.
  - Each cycle: if `mq[0]`=1, add `operand` into AC using a WIDTH+1-bit sum. Then shift `{carry,ac,mq}` right by 1.
  - The result cannot overflow 2·WIDTH bits.
- DVI: divides `{ac_in,mq_in}` by `operand`. Quotient goes to `mq_out`, remainder to `ac_out`, and `link_out`=0.
  - Restoring division, WIDTH cycles.
  - Each cycle: shift `{ac,mq}` left. If the WIDTH+1-bit partial remainder is ≥ `operand`, subtract it and set the quotient bit in `mq[0]`.
- NMI: normalises AC:MQ.
  - Each cycle, test for termination. Terminate when any of these holds:
    - `ac[WIDTH-1]` ≠ `ac[WIDTH-2]`;
    - `{ac,mq}` = {2'b11, zeros};
    - `{ac,mq}` = 0.
  - If terminated, go to DONE. Otherwise shift `{ac,mq}` left by 1 and increment SC.
  - `link_out`=0. `sc_out` is the number of shifts performed, at most 2·WIDTH−2.
- DONE: drives `done`=1 and `busy`=0 for one cycle, then returns to IDLE. Outputs are held.
- Boundary rules:
  - `start` while busy is ignored.
  - `abort` in any state forces IDLE on the next edge and leaves outputs at their last completed values.
  - `abort` and `start` in the same cycle: `abort` wins and `start` is dropped.
  - `start` in the DONE cycle is ignored.
  - `resetN` low mid-operation clears everything immediately.
- Reserved `op`=11 behaves exactly as NMI.

## Timing
- Reset values: `busy`=0, `done`=0, `ac_out`=0, `mq_out`=0, `link_out`=0, `sc_out`=0, FSM=IDLE.
- Cycle 0 is the start edge.
- MUL and non-overflow DVI: `busy`=1 on cycles 1..WIDTH; `done`=1 on cycle WIDTH+1 (cycle 13 for WIDTH=12).
- Overflow DVI: `done`=1 on cycle 1; `busy` never rises.
- NMI with N shifts: `busy`=1 on cycles 1..N+1; `done`=1 on cycle N+2.
- Outputs update on the same edge that raises `done`. They are stable until the edge after the next accepted start.
- Back-to-back: a new `start` is accepted the cycle after `done`.

## Test plan
- MUL with `ac_in`=0002, `mq_in`=0005, `operand`=0003 (octal, WIDTH=12) → `done` at cycle 13; `ac_out`=0000, `mq_out`=0021, `link_out`=0.
- MUL maximum with `ac_in`=`mq_in`=`operand`=7777 → `ac_out`=7777, `mq_out`=0000; no overflow.
- DVI with `ac_in`=0000, `mq_in`=0144, `operand`=0007 → `done` at cycle 13; `mq_out`=0016, `ac_out`=0002, `link_out`=0.
- DVI overflow:
  - `ac_in`=0010, `operand`=0007 → `done` at cycle 1; `link_out`=1; `ac_out`=0010, `mq_out`=`mq_in`.
  - Repeat with `operand`=0000 → same overflow result.
- NMI cases:
  - `ac_in`=0000, `mq_in`=0001 → `ac_out`=2000, `mq_out`=0000, `sc_out`=22 decimal, `done` at cycle 24.
  - All-zero input → `sc_out`=0, `done` at cycle 2.
- Control cases:
  - `abort` at cycle 5 of a MUL → no `done`; outputs unchanged from the previous result.
  - `start` while `busy` → ignored.
  - `resetN` pulled low mid-DVI → all outputs 0 asynchronously.
  - WIDTH=16 regression of the MUL and DVI cases → `done` at cycle 17.
